// File: rtl/tx_hst_notify_pkg.sv
// Shared TLP format constants, FSM state type and DW byte-swap helper
// used by the host notification TLP generator.
package tx_hst_notify_pkg;

  localparam logic [6:0] MEM_WR32_FMT_TYPE = 7'b1000000;
  localparam logic [6:0] MEM_WR64_FMT_TYPE = 7'b1100000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_H0,
    ST_H1,
    ST_D
  } notify_state_t;

  function automatic logic [31:0] dw_endian_conv(input logic [31:0] i_dw);
    dw_endian_conv = {i_dw[7:0], i_dw[15:8], i_dw[23:16], i_dw[31:24]};
  endfunction

endpackage

// File: rtl/tx_hst_notify.sv
// Posts a one-DW memory-write notification to the host each time a local
// buffer fills, alternating fairly between lbuf1 and lbuf2.
module tx_hst_notify
  import tx_hst_notify_pkg::*;
#(
  parameter logic [2:0] NOTIFY_TC = 3'b000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  input  logic        trn_tdst_rdy_n,
  input  logic [3:0]  trn_tbuf_av,
  input  logic [15:0] cfg_completer_id,
  output logic        tx_req,
  input  logic        tx_gnt,
  input  logic [63:0] notify_addr,
  input  logic        notify_addr_vld,
  input  logic        lbuf1_dn,
  input  logic        lbuf2_dn
);

  notify_state_t r_state, w_state_nxt;

  logic        r_pend1, r_pend2, r_last_lbuf2, r_tx_req, r_is64;
  logic [15:0] r_seq;
  logic [1:0]  r_sel;
  logic [63:0] r_addr;
  logic [31:0] r_payload;

  logic [63:0] r_td, w_td_nxt;
  logic [7:0]  r_trem_n, w_trem_nxt;
  logic        r_tsof_n, w_sof_nxt;
  logic        r_teof_n, w_eof_nxt;
  logic        r_tsrc_rdy_n, w_src_nxt;

  logic        w_start, w_eof_acc, w_beat_acc, w_sel_lbuf1;
  logic [1:0]  w_sel;
  logic        w_unused;

  // Header DW0/DW1: length 1, first BE 0xF, last BE 0, tag 0
  function automatic logic [63:0] fmt_hdr(input logic i_is64, input logic [15:0] i_req_id);
    logic [31:0] dw0;
    logic [31:0] dw1;
    dw0 = {1'b0, (i_is64 ? MEM_WR64_FMT_TYPE : MEM_WR32_FMT_TYPE), 1'b0, NOTIFY_TC,
           4'b0000, 2'b00, 2'b00, 2'b00, 10'd1};
    dw1 = {i_req_id, 8'h00, 4'h0, 4'hF};
    fmt_hdr = {dw0, dw1};
  endfunction

  assign w_beat_acc  = ~r_tsrc_rdy_n & ~trn_tdst_rdy_n;
  assign w_sel_lbuf1 = r_pend1 & (~r_pend2 | r_last_lbuf2);
  assign w_sel       = w_sel_lbuf1 ? 2'b01 : 2'b10;
  assign w_unused    = &{1'b0, notify_addr[1:0], trn_tbuf_av[3:2], trn_tbuf_av[0]};

  always_comb begin
    w_state_nxt = r_state;
    w_td_nxt    = r_td;
    w_trem_nxt  = r_trem_n;
    w_sof_nxt   = r_tsof_n;
    w_eof_nxt   = r_teof_n;
    w_src_nxt   = r_tsrc_rdy_n;
    w_start     = 1'b0;
    w_eof_acc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((r_pend1 | r_pend2) & notify_addr_vld & trn_tbuf_av[1]) begin
          w_start     = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (tx_gnt) begin
          w_state_nxt = ST_H0;
          w_td_nxt    = fmt_hdr(r_is64, cfg_completer_id);
          w_trem_nxt  = 8'h00;
          w_sof_nxt   = 1'b0;
          w_eof_nxt   = 1'b1;
          w_src_nxt   = 1'b0;
        end
      end
      ST_H0: begin
        if (w_beat_acc) begin
          w_state_nxt = ST_H1;
          w_sof_nxt   = 1'b1;
          w_trem_nxt  = 8'h00;
          if (r_is64) begin
            w_td_nxt  = {r_addr[63:32], r_addr[31:2], 2'b00};
            w_eof_nxt = 1'b1;
          end else begin
            w_td_nxt  = {r_addr[31:2], 2'b00, r_payload};
            w_eof_nxt = 1'b0;
          end
        end
      end
      ST_H1: begin
        if (w_beat_acc) begin
          if (r_is64) begin
            w_state_nxt = ST_D;
            w_td_nxt    = {r_payload, 32'h0};
            w_trem_nxt  = 8'h0F;
            w_eof_nxt   = 1'b0;
          end else begin
            w_eof_acc   = 1'b1;
            w_state_nxt = ST_IDLE;
            w_trem_nxt  = 8'h00;
            w_eof_nxt   = 1'b1;
            w_src_nxt   = 1'b1;
          end
        end
      end
      ST_D: begin
        if (w_beat_acc) begin
          w_eof_acc   = 1'b1;
          w_state_nxt = ST_IDLE;
          w_trem_nxt  = 8'h00;
          w_eof_nxt   = 1'b1;
          w_src_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A new dn pulse beats the EOF clear so a refill during send is not lost
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pend1      <= 1'b0;
      r_pend2      <= 1'b0;
      r_seq        <= 16'h0000;
      r_last_lbuf2 <= 1'b1;
      r_tx_req     <= 1'b0;
      r_sel        <= 2'b00;
      r_addr       <= 64'h0;
      r_is64       <= 1'b0;
      r_payload    <= 32'h0;
      r_td         <= 64'h0;
      r_trem_n     <= 8'h00;
      r_tsof_n     <= 1'b1;
      r_teof_n     <= 1'b1;
      r_tsrc_rdy_n <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_td         <= w_td_nxt;
      r_trem_n     <= w_trem_nxt;
      r_tsof_n     <= w_sof_nxt;
      r_teof_n     <= w_eof_nxt;
      r_tsrc_rdy_n <= w_src_nxt;
      r_pend1      <= lbuf1_dn | (r_pend1 & ~(w_eof_acc & r_sel[0]));
      r_pend2      <= lbuf2_dn | (r_pend2 & ~(w_eof_acc & r_sel[1]));
      if (w_start) begin
        r_sel        <= w_sel;
        r_addr       <= notify_addr;
        r_is64       <= |notify_addr[63:32];
        r_payload    <= dw_endian_conv({r_seq, 14'b0, w_sel});
        r_last_lbuf2 <= ~w_sel_lbuf1;
        r_tx_req     <= 1'b1;
      end
      if (w_eof_acc) begin
        r_tx_req <= 1'b0;
        r_seq    <= r_seq + 16'd1;
      end
    end
  end

  assign trn_td         = r_td;
  assign trn_trem_n     = r_trem_n;
  assign trn_tsof_n     = r_tsof_n;
  assign trn_teof_n     = r_teof_n;
  assign trn_tsrc_rdy_n = r_tsrc_rdy_n;
  assign tx_req         = r_tx_req;

endmodule

// File: tb/tb_tx_hst_notify.sv
// Scoreboard bench for tx_hst_notify: a queue of expected TLPs built from a
// notification-level model, drained by a bus monitor that rebuilds each TLP.
module tb_tx_hst_notify;

  localparam logic [2:0] TC = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n;
  logic [3:0]  trn_tbuf_av;
  logic [15:0] cfg_completer_id;
  logic        tx_req, tx_gnt;
  logic [63:0] notify_addr;
  logic        notify_addr_vld, lbuf1_dn, lbuf2_dn;

  logic bpRandom, bpForce, gntRandom;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct packed {
    logic [1:0]       nBeats;
    logic [2:0][63:0] beats;
    logic [7:0]       lastTrem;
  } expTlp_t;

  expTlp_t expQ[$];

  int modelSeq;
  int lastServed;

  tx_hst_notify #(.NOTIFY_TC(TC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .trn_td           (trn_td),
    .trn_trem_n       (trn_trem_n),
    .trn_tsof_n       (trn_tsof_n),
    .trn_teof_n       (trn_teof_n),
    .trn_tsrc_rdy_n   (trn_tsrc_rdy_n),
    .trn_tdst_rdy_n   (trn_tdst_rdy_n),
    .trn_tbuf_av      (trn_tbuf_av),
    .cfg_completer_id (cfg_completer_id),
    .tx_req           (tx_req),
    .tx_gnt           (tx_gnt),
    .notify_addr      (notify_addr),
    .notify_addr_vld  (notify_addr_vld),
    .lbuf1_dn         (lbuf1_dn),
    .lbuf2_dn         (lbuf2_dn)
  );

  always #5 clk = ~clk;

  // Core-side backpressure and arbiter grant, updated just after each rising edge
  always @(posedge clk) begin
    #1;
    trn_tdst_rdy_n = bpRandom ? ($urandom_range(0, 3) == 0) : bpForce;
    tx_gnt         = gntRandom ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] swapBytes(input logic [31:0] v);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++)
      r = r | (((v >> (8 * b)) & 32'hFF) << (8 * (3 - b)));
    return r;
  endfunction

  // Reference model: one notification TLP for lbuf 1 or 2, numbered by completed TLPs
  task automatic pushTlp(input int lbuf, input logic [63:0] addr, input logic [15:0] reqId);
    expTlp_t t;
    logic [31:0] dw0, dw1, pay, lo;
    logic is64;
    is64 = (addr[63:32] != 32'h0);
    dw0  = (is64 ? 32'h6000_0000 : 32'h4000_0000) | (32'(TC) << 20) | 32'd1;
    dw1  = (32'(reqId) << 16) | 32'h0000_000F;
    pay  = swapBytes((32'(modelSeq) << 16) | 32'(lbuf));
    lo   = addr[31:0] & 32'hFFFF_FFFC;
    t = '0;
    t.beats[0] = {dw0, dw1};
    if (is64) begin
      t.nBeats   = 2'd3;
      t.beats[1] = {addr[63:32], lo};
      t.beats[2] = {pay, 32'h0};
      t.lastTrem = 8'h0F;
    end else begin
      t.nBeats   = 2'd2;
      t.beats[1] = {lo, pay};
      t.lastTrem = 8'h00;
    end
    expQ.push_back(t);
    modelSeq   = (modelSeq + 1) % 65536;
    lastServed = lbuf;
  endtask

  // Monitor: rebuilds accepted TLPs, checks stall stability and idle strobes
  logic [2:0][63:0] gotBeats;
  int               beatIdx = 0;
  logic             inTlp = 1'b0;
  logic             prevStall = 1'b0;
  logic [63:0]      prevTd;
  logic [7:0]       prevTrem;
  logic             prevSof, prevEof;

  always @(negedge clk) begin
    expTlp_t e;
    if (!rst_n) begin
      inTlp     = 1'b0;
      beatIdx   = 0;
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stallTd",     trn_td, prevTd);
        checkOutput("stallTrem",   64'(trn_trem_n), 64'(prevTrem));
        checkOutput("stallSof",    64'(trn_tsof_n), 64'(prevSof));
        checkOutput("stallEof",    64'(trn_teof_n), 64'(prevEof));
        checkOutput("stallSrcRdy", 64'(trn_tsrc_rdy_n), 64'(0));
      end
      if (!trn_tsrc_rdy_n) begin
        checkOutput("txReqDuringTlp", 64'(tx_req), 64'(1));
        if (!trn_tdst_rdy_n) begin
          checkOutput("sofOnFirstBeat", 64'(!trn_tsof_n), 64'(!inTlp));
          if (!trn_tsof_n || !inTlp) begin
            inTlp   = 1'b1;
            beatIdx = 0;
          end
          if (beatIdx < 3) gotBeats[beatIdx] = trn_td;
          beatIdx++;
          if (!trn_teof_n) begin
            if (expQ.size() == 0) begin
              checkOutput("unexpectedTlp", 64'(1), 64'(0));
            end else begin
              e = expQ.pop_front();
              checkOutput("beatCount", 64'(beatIdx), 64'(e.nBeats));
              for (int i = 0; i < 3; i++)
                if (i < int'(e.nBeats)) checkOutput($sformatf("beat%0d", i), gotBeats[i], e.beats[i]);
              checkOutput("lastTrem", 64'(trn_trem_n), 64'(e.lastTrem));
            end
            inTlp   = 1'b0;
            beatIdx = 0;
          end else if (beatIdx >= 3) begin
            checkOutput("tlpTooLong", 64'(beatIdx), 64'(2));
          end
        end
      end else begin
        checkOutput("idleSof", 64'(trn_tsof_n), 64'(1));
        checkOutput("idleEof", 64'(trn_teof_n), 64'(1));
      end
      prevStall = !trn_tsrc_rdy_n && trn_tdst_rdy_n;
      prevTd    = trn_td;
      prevTrem  = trn_trem_n;
      prevSof   = trn_tsof_n;
      prevEof   = trn_teof_n;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits until every expected TLP has been seen and the block is back at rest
  task automatic waitIdle(input int budget, input string name);
    int n;
    n = 0;
    while ((expQ.size() != 0 || !trn_tsrc_rdy_n || tx_req) && n < budget) begin
      tick();
      n++;
    end
    checkOutput({name, "Queue"}, 64'(expQ.size()), 64'(0));
    checkOutput({name, "TxReq"}, 64'(tx_req), 64'(0));
  endtask

  // mode 0 plain, 1 change address after latch, 2 stall H1 for 5 cycles,
  // 3 re-pulse lbuf1 on the EOF acceptance cycle
  task automatic applyStimulus(input bit p1, input bit p2, input int reps,
                               input logic [63:0] addr, input int gateCycles, input int mode);
    bit found;
    notify_addr_vld = 1'b0;
    for (int r = 0; r < reps; r++) begin
      lbuf1_dn = p1 && (r == 0 || $urandom_range(0, 1) == 1);
      lbuf2_dn = p2 && (r == 0 || $urandom_range(0, 1) == 1);
      tick();
      lbuf1_dn = 1'b0;
      lbuf2_dn = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    checkOutput("vldGateNoReq", 64'(tx_req), 64'(0));
    if (p1 && p2) begin
      if (lastServed == 2) begin
        pushTlp(1, addr, cfg_completer_id);
        pushTlp(2, addr, cfg_completer_id);
      end else begin
        pushTlp(2, addr, cfg_completer_id);
        pushTlp(1, addr, cfg_completer_id);
      end
    end else begin
      pushTlp(p1 ? 1 : 2, addr, cfg_completer_id);
    end
    notify_addr     = addr;
    trn_tbuf_av     = (gateCycles > 0) ? 4'hD : 4'hF;
    notify_addr_vld = 1'b1;
    for (int g = 0; g < gateCycles; g++) begin
      tick();
      checkOutput("tbufGateNoReq", 64'(tx_req), 64'(0));
    end
    trn_tbuf_av = 4'hF;
    if (mode == 1) begin
      found = 1'b0;
      for (int w = 0; w < 20 && !found; w++) begin
        tick();
        found = tx_req;
      end
      checkOutput("waitTxReq", 64'(found), 64'(1));
      notify_addr     = {~addr[63:32] | 32'h1, ~addr[31:0] & 32'hFFFF_FFFC};
      notify_addr_vld = 1'b0;
    end else if (mode == 2) begin
      found = 1'b0;
      for (int w = 0; w < 30 && !found; w++) begin
        @(negedge clk);
        found = !trn_tsrc_rdy_n && !trn_tsof_n;
      end
      checkOutput("waitH0", 64'(found), 64'(1));
      @(posedge clk);
      bpForce = 1'b1;
      repeat (5) @(posedge clk);
      bpForce = 1'b0;
    end else if (mode == 3) begin
      found = 1'b0;
      for (int w = 0; w < 30 && !found; w++) begin
        @(negedge clk);
        found = !trn_tsrc_rdy_n && !trn_teof_n && !trn_tdst_rdy_n;
      end
      checkOutput("waitEof", 64'(found), 64'(1));
      lbuf1_dn = 1'b1;
      pushTlp(1, addr, cfg_completer_id);
      tick();
      lbuf1_dn = 1'b0;
    end
    waitIdle(400, "drain");
    notify_addr_vld = 1'b0;
    tick();
  endtask

  // Synchronous reset while the header beat is stalled; nothing may resume afterwards
  task automatic resetDuringH0();
    bit found;
    notify_addr_vld = 1'b0;
    bpForce         = 1'b1;
    lbuf1_dn        = 1'b1;
    lbuf2_dn        = 1'b1;
    tick();
    lbuf1_dn        = 1'b0;
    lbuf2_dn        = 1'b0;
    notify_addr     = 64'h0000_0000_0000_5000;
    notify_addr_vld = 1'b1;
    found = 1'b0;
    for (int w = 0; w < 30 && !found; w++) begin
      @(negedge clk);
      found = !trn_tsrc_rdy_n && !trn_tsof_n;
    end
    checkOutput("waitH0ForReset", 64'(found), 64'(1));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midResetTd",     trn_td, 64'h0);
    checkOutput("midResetTrem",   64'(trn_trem_n), 64'(0));
    checkOutput("midResetSof",    64'(trn_tsof_n), 64'(1));
    checkOutput("midResetEof",    64'(trn_teof_n), 64'(1));
    checkOutput("midResetSrcRdy", 64'(trn_tsrc_rdy_n), 64'(1));
    checkOutput("midResetTxReq",  64'(tx_req), 64'(0));
    expQ.delete();
    modelSeq   = 0;
    lastServed = 2;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    bpForce = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      checkOutput("noSurvivorReq", 64'(tx_req), 64'(0));
      checkOutput("noSurvivorSrc", 64'(trn_tsrc_rdy_n), 64'(1));
    end
    notify_addr_vld = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] a;
    bit p1, p2;
    rst_n            = 1'b0;
    bpRandom         = 1'b0;
    bpForce          = 1'b0;
    gntRandom        = 1'b0;
    trn_tdst_rdy_n   = 1'b0;
    tx_gnt           = 1'b1;
    trn_tbuf_av      = 4'hF;
    cfg_completer_id = 16'hBEEF;
    notify_addr      = 64'h0;
    notify_addr_vld  = 1'b0;
    lbuf1_dn         = 1'b0;
    lbuf2_dn         = 1'b0;
    modelSeq         = 0;
    lastServed       = 2;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetTd",     trn_td, 64'h0);
    checkOutput("resetTrem",   64'(trn_trem_n), 64'(0));
    checkOutput("resetSof",    64'(trn_tsof_n), 64'(1));
    checkOutput("resetEof",    64'(trn_teof_n), 64'(1));
    checkOutput("resetSrcRdy", 64'(trn_tsrc_rdy_n), 64'(1));
    checkOutput("resetTxReq",  64'(tx_req), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Directed cases: simultaneous pulses, MWr32, MWr64, coalescing, stalls, latch, re-pulse
    applyStimulus(1, 1, 1, 64'h0000_0000_1234_5670, 0, 0);
    applyStimulus(1, 0, 1, 64'h0000_0000_1234_5670, 0, 0);
    applyStimulus(1, 0, 1, 64'h0000_0001_0000_0040, 0, 0);
    applyStimulus(0, 1, 3, 64'h0000_0000_8000_0100, 4, 0);
    applyStimulus(0, 1, 1, 64'h0000_00AB_CDEF_0010, 0, 2);
    applyStimulus(1, 0, 1, 64'h0000_0000_0000_2000, 0, 2);
    applyStimulus(1, 0, 1, 64'h0000_0000_4000_0000, 0, 1);
    applyStimulus(1, 0, 1, 64'h0000_0000_0000_3000, 0, 3);
    resetDuringH0();
    applyStimulus(1, 1, 1, 64'h0000_0002_0000_0800, 0, 0);

    // Randomised traffic with backpressure and grant jitter
    bpRandom  = 1'b1;
    gntRandom = 1'b1;
    for (int it = 0; it < 30; it++) begin
      cfg_completer_id = 16'($urandom);
      p1 = 1'($urandom_range(0, 1));
      p2 = 1'($urandom_range(0, 1));
      if (!p1 && !p2) p1 = 1'b1;
      a[63:32] = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'h0;
      a[31:0]  = 32'($urandom) & 32'hFFFF_FFFC;
      applyStimulus(p1, p2, $urandom_range(1, 3), a, $urandom_range(0, 3), 0);
    end
    bpRandom  = 1'b0;
    gntRandom = 1'b0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
